// File: rtl/box_muller_trig_unit_pkg.sv
// Shared constants, quadrant codes and FSM states for the Box-Muller trig stage.
// Optional sigma scaling is selected with the SIGMA_SCALE_EN macro.
package box_muller_trig_unit_pkg;

  localparam int unsigned H_W       = 16;
  localparam int unsigned LUT_AW    = 9;
  localparam int unsigned FRAC_W    = 5;
  localparam int unsigned P_W       = LUT_AW + FRAC_W;   // phase bits inside a quadrant
  localparam int unsigned U2_W      = 2 + P_W;
  localparam int unsigned G_W       = 17;
  localparam int unsigned TRIG_W    = 15;                // ROM / interpolated value width
  localparam int unsigned TRIG_FRAC = 14;                // trig values are Q1.14
  localparam int unsigned ROM_AW    = LUT_AW + 1;        // must reach index 512
  localparam int unsigned LUT_DEPTH = 513;
  localparam int unsigned ONE_Q14   = 16384;
  localparam int unsigned SIGMA_W   = 16;
  localparam int unsigned SIGMA_FRAC = 12;

  localparam logic [ROM_AW-1:0] LastIdx = ROM_AW'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdSin,
    StRdCos,
    StInterp,
    StMult,
`ifdef SIGMA_SCALE_EN
    StScale,
`endif
    StOut
  } state_e;

  // Upper interpolation point, clamped to the last table entry.
  function automatic logic [ROM_AW-1:0] next_idx(input logic [ROM_AW-1:0] i);
    return (i >= LastIdx) ? LastIdx : i + 1'b1;
  endfunction

endpackage

// File: rtl/box_muller_trig_unit_if.sv
// Valid/ready transaction bundle for the Box-Muller trig stage.
// sigma_in exists only when SIGMA_SCALE_EN is defined.
interface box_muller_trig_unit_if;
  import box_muller_trig_unit_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [H_W-1:0]        h_in;
  logic [U2_W-1:0]       u2_in;
`ifdef SIGMA_SCALE_EN
  logic [SIGMA_W-1:0]    sigma_in;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic signed [G_W-1:0] g0;
  logic signed [G_W-1:0] g1;

  modport master (
    output in_valid,
    output h_in,
    output u2_in,
`ifdef SIGMA_SCALE_EN
    output sigma_in,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  g0,
    input  g1
  );

  modport slave (
    input  in_valid,
    input  h_in,
    input  u2_in,
`ifdef SIGMA_SCALE_EN
    input  sigma_in,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output g0,
    output g1
  );

endinterface

// File: rtl/sin_quarter_rom.sv
// Dual-port synchronous quarter-wave sine ROM: S[i] = round(16384*sin(i*pi/1024)), i = 0..512.
// Contents are computed at elaboration from a Taylor series.
module sin_quarter_rom
  import box_muller_trig_unit_pkg::*;
(
  input  logic              clka,
  input  logic [ROM_AW-1:0] addra,
  output logic [TRIG_W-1:0] douta,
  input  logic              clkb,
  input  logic [ROM_AW-1:0] addrb,
  output logic [TRIG_W-1:0] doutb
);

  localparam real Pi = 3.14159265358979323846;

  function automatic int sin_q14(input int idx);
    real x;
    real term;
    real sum;
    x    = real'(idx) * Pi / 1024.0;
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return $rtoi(sum * 16384.0 + 0.5);
  endfunction

  logic [TRIG_W-1:0] table_w [LUT_DEPTH];

  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_tab
    localparam logic [TRIG_W-1:0] Val = TRIG_W'(sin_q14(gi));
    assign table_w[gi] = Val;
  end

  // Port A read, one-cycle latency.
  always_ff @(posedge clka) begin
    douta <= table_w[addra];
  end

  // Port B read, one-cycle latency.
  always_ff @(posedge clkb) begin
    doutb <= table_w[addrb];
  end

endmodule

// File: rtl/box_muller_trig_unit.sv
// Box-Muller trig stage: g0 = h*cos(2*pi*u2), g1 = h*sin(2*pi*u2) from an interpolated
// quarter-wave ROM. Define SIGMA_SCALE_EN to add sigma_in and a saturating SCALE step.
module box_muller_trig_unit
  import box_muller_trig_unit_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  box_muller_trig_unit_if.slave bus
);

  state_e state_q, state_d;

  logic [H_W-1:0]        h_q;
  logic [U2_W-1:0]       u2_q;
`ifdef SIGMA_SCALE_EN
  logic [SIGMA_W-1:0]    sigma_q;
`endif
  logic [TRIG_W-1:0]     s_lo_q, s_hi_q;
  logic [TRIG_W-1:0]     cos_mag_q, sin_mag_q, cos_mag_d, sin_mag_d;
  logic                  cos_neg_q, sin_neg_q, cos_neg_d, sin_neg_d;
  logic signed [G_W-1:0] g0_q, g1_q, g0_mult, g1_mult;

  logic [P_W-1:0]        p;
  logic [P_W:0]          pc;
  quadrant_e             quad;
  logic [ROM_AW-1:0]     sin_i, cos_i, addr_a, addr_b;
  logic [FRAC_W-1:0]     sin_f, cos_f;
  logic [TRIG_W-1:0]     rom_a, rom_b, sv, cv;

  localparam logic [P_W:0] OneQ14 = (P_W + 1)'(ONE_Q14);

  function automatic logic [TRIG_W-1:0] interp(input logic [TRIG_W-1:0] lo,
                                               input logic [TRIG_W-1:0] hi,
                                               input logic [FRAC_W-1:0] f);
    logic [TRIG_W+FRAC_W-1:0] prod;
    // Table is monotonic over the quarter wave, so hi - lo never wraps.
    prod = (TRIG_W + FRAC_W)'(hi - lo) * (TRIG_W + FRAC_W)'(f);
    return lo + prod[TRIG_W+FRAC_W-1:FRAC_W];
  endfunction

  function automatic logic signed [G_W-1:0] apply_h(input logic [H_W-1:0] h,
                                                    input logic [TRIG_W-1:0] mag,
                                                    input logic neg);
    logic [H_W+TRIG_W-1:0] prod;
    logic [G_W-1:0]        m;
    prod = (H_W + TRIG_W)'(h) * (H_W + TRIG_W)'(mag);
    m    = prod[H_W+TRIG_W-1:TRIG_FRAC];
    // Negating a zero magnitude still yields zero in two's complement.
    return neg ? -$signed(m) : $signed(m);
  endfunction

`ifdef SIGMA_SCALE_EN
  localparam int unsigned SW = G_W + SIGMA_W + 1;

  function automatic logic signed [G_W-1:0] scale(input logic signed [G_W-1:0] g,
                                                  input logic [SIGMA_W-1:0] s);
    logic signed [SW-1:0] gx, sx, prod, shr;
    gx   = SW'(g);
    sx   = SW'($signed({1'b0, s}));
    prod = gx * sx;
    shr  = prod >>> SIGMA_FRAC;
    if (shr > 34'sd65535) begin
      return {1'b0, {(G_W - 1){1'b1}}};
    end else if (shr < -34'sd65536) begin
      return {1'b1, {(G_W - 1){1'b0}}};
    end
    return shr[G_W-1:0];
  endfunction
`endif

  // Phase decomposition into ROM index/fraction for the sin and cos paths.
  always_comb begin
    p      = u2_q[P_W-1:0];
    quad   = quadrant_e'(u2_q[U2_W-1:P_W]);
    pc     = OneQ14 - {1'b0, p};
    sin_i  = {1'b0, p[P_W-1:FRAC_W]};
    sin_f  = p[FRAC_W-1:0];
    cos_i  = pc[P_W:FRAC_W];
    cos_f  = pc[FRAC_W-1:0];
    addr_a = (state_q == StRdSin) ? sin_i : cos_i;
    addr_b = next_idx(addr_a);
  end

  sin_quarter_rom u_rom (
    .clka  (clk),
    .addra (addr_a),
    .douta (rom_a),
    .clkb  (clk),
    .addrb (addr_b),
    .doutb (rom_b)
  );

  // Interpolate both paths and fold into the quadrant's cos/sin magnitudes and signs.
  always_comb begin
    sv        = interp(s_lo_q, s_hi_q, sin_f);
    cv        = interp(rom_a, rom_b, cos_f);
    cos_mag_d = cv;
    sin_mag_d = sv;
    cos_neg_d = 1'b0;
    sin_neg_d = 1'b0;
    unique case (quad)
      Q0: begin cos_mag_d = cv; sin_mag_d = sv; end
      Q1: begin cos_mag_d = sv; cos_neg_d = 1'b1; sin_mag_d = cv; end
      Q2: begin cos_mag_d = cv; cos_neg_d = 1'b1; sin_mag_d = sv; sin_neg_d = 1'b1; end
      Q3: begin cos_mag_d = sv; sin_mag_d = cv; sin_neg_d = 1'b1; end
    endcase
    g0_mult = apply_h(h_q, cos_mag_q, cos_neg_q);
    g1_mult = apply_h(h_q, sin_mag_q, sin_neg_q);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = (state_q == StIdle) && !reset;
    bus.out_valid = (state_q == StOut);
    bus.g0        = g0_q;
    bus.g1        = g1_q;
    unique case (state_q)
      StIdle:   if (bus.in_valid) state_d = StRdSin;
      StRdSin:  state_d = StRdCos;
      StRdCos:  state_d = StInterp;
      StInterp: state_d = StMult;
`ifdef SIGMA_SCALE_EN
      StMult:   state_d = StScale;
      StScale:  state_d = StOut;
`else
      StMult:   state_d = StOut;
`endif
      StOut:    if (bus.out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath registers, each loaded in the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q       <= '0;
      u2_q      <= '0;
`ifdef SIGMA_SCALE_EN
      sigma_q   <= '0;
`endif
      s_lo_q    <= '0;
      s_hi_q    <= '0;
      cos_mag_q <= '0;
      sin_mag_q <= '0;
      cos_neg_q <= 1'b0;
      sin_neg_q <= 1'b0;
      g0_q      <= '0;
      g1_q      <= '0;
    end else begin
      if (state_q == StIdle && bus.in_valid) begin
        h_q     <= bus.h_in;
        u2_q    <= bus.u2_in;
`ifdef SIGMA_SCALE_EN
        sigma_q <= bus.sigma_in;
`endif
      end
      if (state_q == StRdCos) begin
        s_lo_q <= rom_a;
        s_hi_q <= rom_b;
      end
      if (state_q == StInterp) begin
        cos_mag_q <= cos_mag_d;
        sin_mag_q <= sin_mag_d;
        cos_neg_q <= cos_neg_d;
        sin_neg_q <= sin_neg_d;
      end
      if (state_q == StMult) begin
        g0_q <= g0_mult;
        g1_q <= g1_mult;
      end
`ifdef SIGMA_SCALE_EN
      if (state_q == StScale) begin
        g0_q <= scale(g0_q, sigma_q);
        g1_q <= scale(g1_q, sigma_q);
      end
`endif
    end
  end

endmodule
